// File: rtl/mips_bus_control_fsm.sv
// Multi-cycle bus sequencer for the MIPS core: FETCH/DECODE/EXEC/MEM/WB
// with waitrequest and mul/div stalls, delay-slot tracking and halt.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   opcode, funct     IR fields of the instruction in flight
//   waitrequest       bus stall, holds the current read/write
//   mem_read_req      MemRead from control_unit
//   mem_write_req     MemWrite from control_unit
//   delay_early       instruction is a jump/branch with a delay slot
//   target_is_zero    taken jump/branch target is address 0
//   state             FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 STALL=5 HALT=6 FAULT=7
//   active            0 once halted or faulted
//   read, write       bus strobes (never both high)
//   ir_we, pc_we      instruction latch / PC commit
//   reg_we_en         regfile write window
//   hilo_we_en        HI/LO write window
//   delay_slot        current instruction sits in a delay slot
//   bus_error         sticky watchdog flag
//
// Optional feature: define BUS_TIMEOUT_EN to enable the bus watchdog that
// moves to FAULT after TIMEOUT_CYCLES consecutive waitrequest cycles.
module mips_bus_control_fsm #(
  parameter int MULDIV_CYCLES  = 32,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       waitrequest,
  input  logic       mem_read_req,
  input  logic       mem_write_req,
  input  logic       delay_early,
  input  logic       target_is_zero,
  output logic [2:0] state,
  output logic       active,
  output logic       read,
  output logic       write,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we_en,
  output logic       hilo_we_en,
  output logic       delay_slot,
  output logic       bus_error
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_STALL  = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  if (MULDIV_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mips_bus_control_fsm: cycle parameters must be >= 1");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             delay_slot_q, delay_slot_d;
  logic             halt_pending_q, halt_pending_d;
  logic             from_stall_q, from_stall_d;

`ifdef BUS_TIMEOUT_EN
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             bus_error_q, bus_error_d;
`endif

  logic is_muldiv;
  logic is_mthilo;

  // MULT/MULTU/DIV/DIVU and MTHI/MTLO, all SPECIAL-opcode encodings
  assign is_muldiv = (opcode == 6'h00) &&
                     (funct[5:2] == 4'b0110);
  assign is_mthilo = (opcode == 6'h00) &&
                     ((funct == 6'h11) || (funct == 6'h13));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    delay_slot_d   = delay_slot_q;
    halt_pending_d = halt_pending_q;
    from_stall_d   = from_stall_q;
`ifdef BUS_TIMEOUT_EN
    wcnt_d         = '0;
    bus_error_d    = bus_error_q;
`endif
    unique case (state_q)
      S_FETCH: begin
        if (!waitrequest) state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_muldiv) begin
          state_d      = S_STALL;
          cnt_d        = CNT_W'(MULDIV_CYCLES - 1);
          from_stall_d = 1'b1;
        end else if (mem_read_req || mem_write_req) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_STALL: begin
        if (cnt_q == '0) state_d = S_WB;
        else cnt_d = cnt_q - 1'b1;
      end
      S_MEM: begin
        if (!waitrequest) state_d = S_WB;
      end
      S_WB: begin
        from_stall_d = 1'b0;
        // a jump in a delay slot simply reloads the flag
        delay_slot_d = delay_early;
        if (delay_early && target_is_zero)
          halt_pending_d = 1'b1;
        // halt_pending_q was set by the previous WB (the jump)
        state_d = halt_pending_q ? S_HALT : S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
    endcase
`ifdef BUS_TIMEOUT_EN
    if ((state_q == S_FETCH || state_q == S_MEM) &&
        waitrequest) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d     = S_FAULT;
        bus_error_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_FETCH;
      cnt_q          <= '0;
      delay_slot_q   <= 1'b0;
      halt_pending_q <= 1'b0;
      from_stall_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      wcnt_q         <= '0;
      bus_error_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      delay_slot_q   <= delay_slot_d;
      halt_pending_q <= halt_pending_d;
      from_stall_q   <= from_stall_d;
`ifdef BUS_TIMEOUT_EN
      wcnt_q         <= wcnt_d;
      bus_error_q    <= bus_error_d;
`endif
    end
  end

  // Strobes are gated by reset so a transfer drops the moment reset rises
  always_comb begin
    read       = 1'b0;
    write      = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we_en  = 1'b0;
    hilo_we_en = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          read  = 1'b1;
          ir_we = !waitrequest;
        end
        S_MEM: begin
          read  = mem_read_req;
          write = mem_write_req && !mem_read_req;
        end
        S_WB: begin
          pc_we      = 1'b1;
          reg_we_en  = 1'b1;
          hilo_we_en = from_stall_q || is_mthilo;
        end
        S_DECODE, S_EXEC, S_STALL,
        S_HALT, S_FAULT: begin
          read = 1'b0;
        end
      endcase
    end
  end

  assign state      = state_q;
  assign active     = (state_q != S_HALT) &&
                      (state_q != S_FAULT);
  assign delay_slot = delay_slot_q;

`ifdef BUS_TIMEOUT_EN
  assign bus_error = bus_error_q;
`else
  assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mips_bus_control_fsm.sv
// Directed bench for mips_bus_control_fsm: cycle table plus
// hand sequences for reset mid-transfer and the bus watchdog.
module tb_mips_bus_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       waitrequest, mem_read_req, mem_write_req;
  logic       delay_early, target_is_zero;
  logic [2:0] state;
  logic       active, read, write, ir_we, pc_we;
  logic       reg_we_en, hilo_we_en, delay_slot, bus_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_bus_control_fsm #(
    .MULDIV_CYCLES(4),
    .TIMEOUT_CYCLES(8),
    .CNT_W(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .opcode(opcode),
    .funct(funct),
    .waitrequest(waitrequest),
    .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req),
    .delay_early(delay_early),
    .target_is_zero(target_is_zero),
    .state(state),
    .active(active),
    .read(read),
    .write(write),
    .ir_we(ir_we),
    .pc_we(pc_we),
    .reg_we_en(reg_we_en),
    .hilo_we_en(hilo_we_en),
    .delay_slot(delay_slot),
    .bus_error(bus_error)
  );

  localparam logic [7:0] A  = 8'h80;
  localparam logic [7:0] RD = 8'h40;
  localparam logic [7:0] WR = 8'h20;
  localparam logic [7:0] IR = 8'h10;
  localparam logic [7:0] PC = 8'h08;
  localparam logic [7:0] RG = 8'h04;
  localparam logic [7:0] HL = 8'h02;
  localparam logic [7:0] DS = 8'h01;
  localparam logic [7:0] WB = A | PC | RG;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       w;
    logic       mrd;
    logic       mwr;
    logic       de;
    logic       tz;
    logic [2:0] st;
    logic [7:0] fl;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [5:0] op, input logic [5:0] fn,
                     input logic w, input logic mrd, input logic mwr,
                     input logic de, input logic tz,
                     input logic [2:0] st, input logic [7:0] fl);
    vec_t v;
    v.op = op; v.fn = fn; v.w = w; v.mrd = mrd; v.mwr = mwr;
    v.de = de; v.tz = tz; v.st = st; v.fl = fl;
    vq.push_back(v);
  endtask

  function automatic logic [10:0] outs();
    return {state, active, read, write, ir_we,
            pc_we, reg_we_en, hilo_we_en, delay_slot};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic w, input logic mrd, input logic mwr);
    opcode = op; funct = fn; waitrequest = w;
    mem_read_req = mrd; mem_write_req = mwr;
    delay_early = 1'b0; target_is_zero = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(6'h00, 6'h00, 1'b0, 1'b0, 1'b0);

    // ADDU
    add(6'h00, 6'h21, 0, 0, 0, 0, 0, 3'd0, A | RD | IR);
    add(6'h00, 6'h21, 0, 0, 0, 0, 0, 3'd1, A);
    add(6'h00, 6'h21, 0, 0, 0, 0, 0, 3'd2, A);
    add(6'h00, 6'h21, 0, 0, 0, 0, 0, 3'd4, WB);
    // LW, three waitrequest cycles in MEM
    add(6'h23, 6'h00, 0, 1, 0, 0, 0, 3'd0, A | RD | IR);
    add(6'h23, 6'h00, 0, 1, 0, 0, 0, 3'd1, A);
    add(6'h23, 6'h00, 0, 1, 0, 0, 0, 3'd2, A);
    add(6'h23, 6'h00, 1, 1, 0, 0, 0, 3'd3, A | RD);
    add(6'h23, 6'h00, 1, 1, 0, 0, 0, 3'd3, A | RD);
    add(6'h23, 6'h00, 1, 1, 0, 0, 0, 3'd3, A | RD);
    add(6'h23, 6'h00, 0, 1, 0, 0, 0, 3'd3, A | RD);
    add(6'h23, 6'h00, 0, 1, 0, 0, 0, 3'd4, WB);
    // SW, one waitrequest cycle in FETCH
    add(6'h2B, 6'h00, 1, 0, 1, 0, 0, 3'd0, A | RD);
    add(6'h2B, 6'h00, 0, 0, 1, 0, 0, 3'd0, A | RD | IR);
    add(6'h2B, 6'h00, 0, 0, 1, 0, 0, 3'd1, A);
    add(6'h2B, 6'h00, 0, 0, 1, 0, 0, 3'd2, A);
    add(6'h2B, 6'h00, 0, 0, 1, 0, 0, 3'd3, A | WR);
    add(6'h2B, 6'h00, 0, 0, 1, 0, 0, 3'd4, WB);
    // MULT, four STALL cycles
    add(6'h00, 6'h18, 0, 0, 0, 0, 0, 3'd0, A | RD | IR);
    add(6'h00, 6'h18, 0, 0, 0, 0, 0, 3'd1, A);
    add(6'h00, 6'h18, 0, 0, 0, 0, 0, 3'd2, A);
    for (int i = 0; i < 4; i++)
      add(6'h00, 6'h18, 0, 0, 0, 0, 0, 3'd5, A);
    add(6'h00, 6'h18, 0, 0, 0, 0, 0, 3'd4, WB | HL);
    // MTHI
    add(6'h00, 6'h11, 0, 0, 0, 0, 0, 3'd0, A | RD | IR);
    add(6'h00, 6'h11, 0, 0, 0, 0, 0, 3'd1, A);
    add(6'h00, 6'h11, 0, 0, 0, 0, 0, 3'd2, A);
    add(6'h00, 6'h11, 0, 0, 0, 0, 0, 3'd4, WB | HL);
    // BEQ to nonzero target, then ADDU in its delay slot
    add(6'h04, 6'h00, 0, 0, 0, 1, 0, 3'd0, A | RD | IR);
    add(6'h04, 6'h00, 0, 0, 0, 1, 0, 3'd1, A);
    add(6'h04, 6'h00, 0, 0, 0, 1, 0, 3'd2, A);
    add(6'h04, 6'h00, 0, 0, 0, 1, 0, 3'd4, WB);
    add(6'h00, 6'h21, 0, 0, 0, 0, 0, 3'd0, A | RD | IR | DS);
    add(6'h00, 6'h21, 0, 0, 0, 0, 0, 3'd1, A | DS);
    add(6'h00, 6'h21, 0, 0, 0, 0, 0, 3'd2, A | DS);
    add(6'h00, 6'h21, 0, 0, 0, 0, 0, 3'd4, WB | DS);
    // JR to 0, then NOP in the slot, then HALT
    add(6'h00, 6'h08, 0, 0, 0, 1, 1, 3'd0, A | RD | IR);
    add(6'h00, 6'h08, 0, 0, 0, 1, 1, 3'd1, A);
    add(6'h00, 6'h08, 0, 0, 0, 1, 1, 3'd2, A);
    add(6'h00, 6'h08, 0, 0, 0, 1, 1, 3'd4, WB);
    add(6'h00, 6'h00, 0, 0, 0, 0, 0, 3'd0, A | RD | IR | DS);
    add(6'h00, 6'h00, 0, 0, 0, 0, 0, 3'd1, A | DS);
    add(6'h00, 6'h00, 0, 0, 0, 0, 0, 3'd2, A | DS);
    add(6'h00, 6'h00, 0, 0, 0, 0, 0, 3'd4, WB | DS);
    add(6'h00, 6'h00, 1, 1, 0, 0, 0, 3'd6, 8'h00);
    add(6'h00, 6'h00, 0, 0, 1, 0, 0, 3'd6, 8'h00);

    // reset values while reset is held
    #2;
    chk("rst_outs", 32'(outs()), 32'({3'd0, A}));
    chk("rst_berr", 32'(bus_error), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    foreach (vq[i]) begin
      opcode = vq[i].op; funct = vq[i].fn;
      waitrequest = vq[i].w;
      mem_read_req = vq[i].mrd; mem_write_req = vq[i].mwr;
      delay_early = vq[i].de; target_is_zero = vq[i].tz;
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vq[i].st, vq[i].fl}));
      @(negedge clk);
    end
    chk("tbl_berr", 32'(bus_error), 32'd0);

    // reset asserted in the middle of a store
    reset = 1'b1;
    drive(6'h2B, 6'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mem_wr", 32'({state, read, write}), 32'({3'd3, 2'b01}));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid", 32'({state, read, write}), 32'({3'd0, 2'b00}));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rel", 32'({state, read, write}), 32'({3'd0, 2'b10}));

    // waitrequest stuck high in FETCH
    @(negedge clk);
    reset = 1'b1;
    drive(6'h00, 6'h21, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("wd_wait%0d", i), 32'({state, read}),
          32'({3'd0, 1'b1}));
      @(negedge clk);
    end
    #1;
`ifdef BUS_TIMEOUT_EN
    chk("wd_fault", 32'({state, bus_error, active, read}),
        32'({3'd7, 3'b100}));
    waitrequest = 1'b0;
    @(negedge clk);
    #1;
    chk("wd_sticky", 32'({state, bus_error, active}),
        32'({3'd7, 2'b10}));
`else
    chk("wd_nofault", 32'({state, bus_error, active, read}),
        32'({3'd0, 3'b011}));
    waitrequest = 1'b0;
    @(negedge clk);
    #1;
    chk("wd_resume", 32'(state), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
